fp_vec3_normalize_folded: RTL and testbench
===========================================

Name: fp_vec3_normalize_folded

Overview:
Normalizes a 3-component Q16.16 vector (ray directions, surface normals) for the ray-tracing pipeline. It is the initiator/client side of the inverse-square-root request interface. It forms the squared length with one shared multiplier, issues a single request to fp_inv_sqrt_folded, waits for the result, then scales each component by it. The design is folded, so one vector is in flight at a time.

Parameters:
WIDTH, 32, total fixed-point width (signed two's complement)
FRAC, 16, fractional bits (Q16.16)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset; synchronous, active-high
x_in, y_in, z_in  input  WIDTH each  vector components
valid_in  input  1  request; accepted when valid_in && ready_out at a rising edge
ready_out  output  1  high only in IDLE
x_out, y_out, z_out  output  WIDTH each  normalized components, held until the next accept
valid_out  output  1  one-cycle pulse when outputs update
zero_out  output  1  input was the zero vector (qualified by valid_out)
sat_out  output  1  squared length saturated (qualified by valid_out)
isq_a_out  output  WIDTH  operand to the inverse-sqrt responder
isq_valid_out  output  1  request valid toward the responder
isq_ready_in  input  1  responder ready (connect to its ready_out)
isq_res_in  input  WIDTH  responder result
isq_valid_in  input  1  responder result valid

Behaviour:
- Reset values: ready_out=1 (state IDLE); valid_out, isq_valid_out, zero_out and sat_out are 0; x/y/z_out and isq_a_out are 0.
- Fixed-point multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC, low WIDTH bits kept (truncation toward -inf).
- FSM states: IDLE, DOT, REQ, WAIT, SCALE, DONE.
- IDLE: on accept, register the inputs, clear the accumulator, go to DOT.
- DOT: 3 cycles; the shared multiplier forms x², y², z² in turn and adds each to an unsigned accumulator one bit wider than WIDTH.
  - Accumulator > 0x7FFFFFFF: clamp to 0x7FFFFFFF and set sat.
  - Accumulator == 0 after 3 cycles: set zero, skip to DONE with x/y/z_out=0; no request is issued.
  - Otherwise go to REQ.
- REQ: isq_a_out=dot and isq_valid_out=1, both held stable until isq_valid_out && isq_ready_in at an edge. At that edge drop isq_valid_out and go to WAIT. isq_ready_in low keeps the FSM in REQ indefinitely.
- WAIT: on isq_valid_in, latch isq_res_in as inv and go to SCALE. isq_valid_in is ignored in every other state.
- SCALE: 3 cycles computing x*inv, y*inv, z*inv on the shared multiplier, then DONE.
- DONE: update outputs, pulse valid_out for 1 cycle, return to IDLE (ready_out high the next cycle).
- Latency, non-zero vector: accept at edge 0, isq_valid_out high cycles 3 onward; if isq_valid_in is sampled at edge k, valid_out is high in cycle k+4.
- Latency, zero vector: valid_out is high in cycle 4.
- Back-to-back: a new valid_in is accepted the cycle after DONE; there is no overlap.
- Reset mid-operation: return to IDLE, drop isq_valid_out. Outputs retain reset values. A late isq_valid_in from an aborted request is discarded. The next request waits on isq_ready_in as usual.
- Negative components are handled; squares are non-negative, and sign carries through SCALE.

Optional Feature:
FP_NORM_LEN_OUT_EN
- Defined: adds output len_out (WIDTH) = dot*inv, the vector length. SCALE becomes 4 cycles, so valid_out shifts to k+5. len_out=0 for the zero vector and is held like the other outputs.
- Undefined: port absent, SCALE is 3 cycles.

Decomposition:
- types.vh: WIDTH/FRAC defaults and the FSM state encoding localparams.
- fixed_point_arith.vh: the fixed-point multiply/shift helper and the saturation constant 0x7FFFFFFF.
- One sub-module, fp_mul_shared: registered-free combinational Q16.16 multiplier with operand mux select, instantiated once.

Test Plan:
Bench pairs the DUT with a behavioural inverse-sqrt responder of fixed latency 5 (swap in fp_inv_sqrt_folded for an integration run). Tolerance is 1e-4.
- (0.6, 0.8, 0) -> isq_a_out=0x00010000; outputs (0.6, 0.8, 0); valid_out in cycle k+4.
- (1, 1, 1) -> isq_a_out=0x00030000; each output 0.57735; zero_out=0, sat_out=0.
- (0, 0, 0) -> isq_valid_out never asserts; valid_out in cycle 4 with zero_out=1 and outputs 0.
- (-0.6, 0, 0.8), responder isq_ready_in held low 20 cycles -> isq_valid_out high and isq_a_out stable throughout; then (-0.6, 0, 0.8), no valid_out before the handshake.
- (200, 200, 200) -> sat_out=1, isq_a_out=0x7FFFFFFF, valid_out still pulses once.
- rst_in for 1 cycle during WAIT, then isq_valid_in arrives -> ignored, valid_out stays 0, ready_out=1 the cycle after reset; a following (0.6, 0.8, 0) normalizes correctly.

Source files
------------

// File: rtl/fp_vec3_normalize_folded_pkg.sv
// Shared definitions for the folded Q16.16 vector normaliser.
//   - FX_WIDTH / FX_FRAC : default word width and fractional bits (Q16.16)
//   - ST_*               : FSM state encoding (3-bit, legacy-compatible constants)
//   - SEL_*              : operand select codes for the shared multiplier
//   - fx_sat_max()       : largest positive value of a WIDTH-bit signed word
package fp_vec3_normalize_folded_pkg;

   localparam int FX_WIDTH = 32;
   localparam int FX_FRAC  = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DOT   = 3'd1;
   localparam logic [2:0] ST_REQ   = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_SCALE = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // Operand A select: the component index doubles as the step counter.
   localparam logic [1:0] SEL_X   = 2'd0;
   localparam logic [1:0] SEL_Y   = 2'd1;
   localparam logic [1:0] SEL_Z   = 2'd2;
   localparam logic [1:0] SEL_DOT = 2'd3;

   // Saturation value for the squared length (0x7FFFFFFF at 32 bits),
   // returned one bit wider so it compares directly against the accumulator.
   function automatic logic [FX_WIDTH:0] fx_sat_max();
      logic [FX_WIDTH:0] v;
      v = '0;
      v[FX_WIDTH-2:0] = '1;
      return v;
   endfunction

endpackage

// File: rtl/fp_vec3_normalize_folded_mul_shared.sv
// fp_mul_shared: combinational Q16.16 multiplier with an operand mux.
// Ports:
//   x, y, z, d   operand A candidates (components, squared length)
//   inv          operand B when not squaring (inverse square root)
//   sel          operand A select (SEL_X/Y/Z/DOT)
//   square       1: B = A (squaring), 0: B = inv
//   prod         (A*B) >>> FRAC, low WIDTH bits (truncates toward -inf)
module fp_mul_shared
   import fp_vec3_normalize_folded_pkg::*;
#(
   parameter int WIDTH = FX_WIDTH,
   parameter int FRAC  = FX_FRAC
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] inv,
   input  logic [1:0]       sel,
   input  logic             square,
   output logic [WIDTH-1:0] prod
);

   logic signed [WIDTH-1:0]   op_a;
   logic signed [WIDTH-1:0]   op_b;
   logic signed [2*WIDTH-1:0] full;
   logic                      unused_bits;

   always_comb begin
      op_a = x;
      case (sel)
         SEL_X:   op_a = x;
         SEL_Y:   op_a = y;
         SEL_Z:   op_a = z;
         default: op_a = d;
      endcase
      op_b = square ? op_a : inv;
   end

   assign full = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) *
                 $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});

   // Taking bits [FRAC+WIDTH-1:FRAC] is the arithmetic shift right by FRAC
   // followed by keeping the low WIDTH bits.
   assign prod        = full[FRAC+WIDTH-1:FRAC];
   assign unused_bits = ^{full[2*WIDTH-1:FRAC+WIDTH], full[FRAC-1:0]};

endmodule

// File: rtl/fp_vec3_normalize_folded.sv
// fp_vec3_normalize_folded: folded Q16.16 3-vector normaliser.
// Forms x^2+y^2+z^2 on one shared multiplier, requests 1/sqrt from an
// external responder, then scales each component by the result.
// One vector in flight at a time.
// Optional macro FP_NORM_LEN_OUT_EN: adds len_out = dot*inv (vector length)
// and lengthens SCALE to 4 cycles.
// Ports:
//   clk_in, rst_in              clock, synchronous active-high reset
//   x_in/y_in/z_in, valid_in    input vector, accepted on valid_in && ready_out
//   ready_out                   high only in IDLE
//   x_out/y_out/z_out           normalised components, held until next accept
//   valid_out                   one-cycle pulse when outputs update
//   zero_out, sat_out           zero vector / squared length clamped (with valid_out)
//   len_out                     vector length (only with FP_NORM_LEN_OUT_EN)
//   isq_a_out, isq_valid_out    request toward the inverse-sqrt responder
//   isq_ready_in                responder ready
//   isq_res_in, isq_valid_in    responder result
//
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both high. The sender holds valid and its data stable until that edge and
// never waits on ready before raising valid. The result path (isq_valid_in)
// has no back-pressure and is only looked at in WAIT.
module fp_vec3_normalize_folded
   import fp_vec3_normalize_folded_pkg::*;
#(
   parameter int WIDTH = FX_WIDTH,
   parameter int FRAC  = FX_FRAC
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out,
   output logic             valid_out,
   output logic             zero_out,
   output logic             sat_out,
`ifdef FP_NORM_LEN_OUT_EN
   output logic [WIDTH-1:0] len_out,
`endif
   output logic [WIDTH-1:0] isq_a_out,
   output logic             isq_valid_out,
   input  logic             isq_ready_in,
   input  logic [WIDTH-1:0] isq_res_in,
   input  logic             isq_valid_in
);

`ifdef FP_NORM_LEN_OUT_EN
   localparam logic [1:0] SCALE_LAST = 2'd3;
`else
   localparam logic [1:0] SCALE_LAST = 2'd2;
`endif

   // Generic form of fx_sat_max(), valid for any WIDTH.
   localparam logic [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};

   logic [2:0]       state;
   logic [1:0]       step;
   logic [WIDTH-1:0] x_r, y_r, z_r;
   logic [WIDTH:0]   acc;
   logic             sat_r;
   logic             zero_r;
   logic [WIDTH-1:0] inv_r;
   logic [WIDTH-1:0] x_s, y_s, z_s;
`ifdef FP_NORM_LEN_OUT_EN
   logic [WIDTH-1:0] l_s;
`endif

   logic [WIDTH-1:0] prod;
   logic [WIDTH:0]   acc_sum;
   logic             acc_over;
   logic [WIDTH:0]   acc_clamped;

   fp_mul_shared #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mul (
      .x      (x_r),
      .y      (y_r),
      .z      (z_r),
      .d      (isq_a_out),
      .inv    (inv_r),
      .sel    (step),
      .square (state == ST_DOT),
      .prod   (prod)
   );

   // Squares are non-negative, so the truncated product is added unsigned.
   // The accumulator is clamped every step, so it never exceeds
   // SAT_MAX + (2^WIDTH - 1) and the extra bit cannot overflow.
   always_comb begin
      acc_sum     = acc + {1'b0, prod};
      acc_over    = acc_sum > SAT_MAX;
      acc_clamped = acc_over ? SAT_MAX : acc_sum;
   end

   assign ready_out = (state == ST_IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= ST_IDLE;
         step          <= '0;
         x_r           <= '0;
         y_r           <= '0;
         z_r           <= '0;
         acc           <= '0;
         sat_r         <= 1'b0;
         zero_r        <= 1'b0;
         inv_r         <= '0;
         x_s           <= '0;
         y_s           <= '0;
         z_s           <= '0;
         x_out         <= '0;
         y_out         <= '0;
         z_out         <= '0;
         valid_out     <= 1'b0;
         zero_out      <= 1'b0;
         sat_out       <= 1'b0;
         isq_a_out     <= '0;
         isq_valid_out <= 1'b0;
`ifdef FP_NORM_LEN_OUT_EN
         l_s           <= '0;
         len_out       <= '0;
`endif
      end else begin
         valid_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_in) begin
                  x_r    <= x_in;
                  y_r    <= y_in;
                  z_r    <= z_in;
                  acc    <= '0;
                  sat_r  <= 1'b0;
                  zero_r <= 1'b0;
                  step   <= '0;
                  state  <= ST_DOT;
               end
            end
            ST_DOT: begin
               acc <= acc_clamped;
               if (acc_over) sat_r <= 1'b1;
               if (step == SEL_Z) begin
                  step <= '0;
                  if (acc_clamped == '0) begin
                     // Zero vector: no request, results forced to zero.
                     zero_r <= 1'b1;
                     x_s    <= '0;
                     y_s    <= '0;
                     z_s    <= '0;
`ifdef FP_NORM_LEN_OUT_EN
                     l_s    <= '0;
`endif
                     state  <= ST_DONE;
                  end else begin
                     isq_a_out     <= acc_clamped[WIDTH-1:0];
                     isq_valid_out <= 1'b1;
                     state         <= ST_REQ;
                  end
               end else begin
                  step <= step + 2'd1;
               end
            end
            ST_REQ: begin
               if (isq_ready_in) begin
                  isq_valid_out <= 1'b0;
                  state         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (isq_valid_in) begin
                  inv_r <= isq_res_in;
                  step  <= '0;
                  state <= ST_SCALE;
               end
            end
            ST_SCALE: begin
               case (step)
                  SEL_X: x_s <= prod;
                  SEL_Y: y_s <= prod;
                  SEL_Z: z_s <= prod;
`ifdef FP_NORM_LEN_OUT_EN
                  SEL_DOT: l_s <= prod;
`endif
                  default: ;
               endcase
               if (step == SCALE_LAST) begin
                  step  <= '0;
                  state <= ST_DONE;
               end else begin
                  step <= step + 2'd1;
               end
            end
            ST_DONE: begin
               x_out     <= x_s;
               y_out     <= y_s;
               z_out     <= z_s;
               zero_out  <= zero_r;
               sat_out   <= sat_r;
`ifdef FP_NORM_LEN_OUT_EN
               len_out   <= l_s;
`endif
               valid_out <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_vec3_normalize_folded.sv
// Bench for fp_vec3_normalize_folded: directed vectors, a behavioural
// inverse-sqrt responder of latency 5, a real-arithmetic model feeding an
// expected queue, and one compare process checking every valid_out pulse.
module tb_fp_vec3_normalize_folded;

   localparam int W   = 32;
   localparam int TOL = 6;  // about 1e-4 in Q16.16 LSBs
`ifdef FP_NORM_LEN_OUT_EN
   localparam int LEN_EXTRA = 1;
`else
   localparam int LEN_EXTRA = 0;
`endif

   localparam logic [W-1:0] Q_ZERO = 32'h00000000;
   localparam logic [W-1:0] Q_ONE  = 32'h00010000;
   localparam logic [W-1:0] Q_0P6  = 32'h0000999A;
   localparam logic [W-1:0] Q_0P8  = 32'h0000CCCD;
   localparam logic [W-1:0] Q_M0P6 = 32'hFFFF6666;
   localparam logic [W-1:0] Q_200  = 32'h00C80000;

   typedef struct packed {
      logic [31:0]  due;
      logic         zero;
      logic         sat;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] z;
      logic [W-1:0] len;
   } exp_t;

   logic         clk_in, rst_in;
   logic [W-1:0] x_in, y_in, z_in;
   logic         valid_in, ready_out;
   logic [W-1:0] x_out, y_out, z_out;
   logic         valid_out, zero_out, sat_out;
   logic [W-1:0] isq_a_out, isq_res_in;
   logic         isq_valid_out, isq_ready_in, isq_valid_in;
`ifdef FP_NORM_LEN_OUT_EN
   logic [W-1:0] len_out;
`endif

   fp_vec3_normalize_folded dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .x_in          (x_in),
      .y_in          (y_in),
      .z_in          (z_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .x_out         (x_out),
      .y_out         (y_out),
      .z_out         (z_out),
      .valid_out     (valid_out),
      .zero_out      (zero_out),
      .sat_out       (sat_out),
`ifdef FP_NORM_LEN_OUT_EN
      .len_out       (len_out),
`endif
      .isq_a_out     (isq_a_out),
      .isq_valid_out (isq_valid_out),
      .isq_ready_in  (isq_ready_in),
      .isq_res_in    (isq_res_in),
      .isq_valid_in  (isq_valid_in)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input bit ok,
                      input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic real q2r(input logic [W-1:0] v);
      return $itor($signed(v)) / 65536.0;
   endfunction

   function automatic logic [W-1:0] to_q(input real r);
      real s;
      s = r * 65536.0;
      if (s >= 2147483647.0) return 32'h7FFFFFFF;
      if (s >= 0.0) return $rtoi(s + 0.5);
      return -$rtoi(-s + 0.5);
   endfunction

   function automatic bit near(input logic [W-1:0] a, input logic [W-1:0] b);
      longint d;
      d = longint'($signed(a)) - longint'($signed(b));
      return (d <= TOL) && (d >= -TOL);
   endfunction

   function automatic logic [W-1:0] inv_sqrt(input logic [W-1:0] a);
      if (a == '0) return '0;
      return $rtoi(65536.0 / $sqrt(q2r(a)) + 0.5);
   endfunction

   // ---------------- model, responder, scoreboard ----------------
   exp_t         exp_q[$];
   logic [W-1:0] pend_x, pend_y, pend_z;
   real          pend_dot;
   bit           pend_sat;
   bit           pend_v = 0;
   int           rsp_cnt = 0;
   logic [W-1:0] rsp_val = '0;
   logic [W-1:0] last_isq_a = '0;
   int           out_cnt = 0;

   initial begin
      exp_t e;
      real  inv_r, d;
      isq_valid_in = 1'b0;
      isq_res_in   = '0;
      forever begin
         @(negedge clk_in);
         #1;
         // Outputs of the current cycle.
         if (!rst_in && valid_out) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 1'b0, 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_latency", cyc == int'(e.due), cyc, e.due);
               chk("out_x", near(x_out, e.x), x_out, e.x);
               chk("out_y", near(y_out, e.y), y_out, e.y);
               chk("out_z", near(z_out, e.z), z_out, e.z);
               chk("out_zero", zero_out == e.zero, zero_out, e.zero);
               chk("out_sat", sat_out == e.sat, sat_out, e.sat);
`ifdef FP_NORM_LEN_OUT_EN
               chk("out_len", near(len_out, e.len), len_out, e.len);
`endif
            end
         end
         // Responder: result presented for the coming edge.
         isq_valid_in = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               isq_valid_in = 1'b1;
               isq_res_in   = rsp_val;
               if (pend_v) begin
                  inv_r = q2r(rsp_val);
                  e.due  = cyc + 1 + 4 + LEN_EXTRA;
                  e.zero = 1'b0;
                  e.sat  = pend_sat;
                  e.x    = to_q(q2r(pend_x) * inv_r);
                  e.y    = to_q(q2r(pend_y) * inv_r);
                  e.z    = to_q(q2r(pend_z) * inv_r);
                  e.len  = to_q(pend_dot * inv_r);
                  exp_q.push_back(e);
                  pend_v = 0;
               end
            end
         end
         if (rst_in) begin
            pend_v = 0;
            exp_q.delete();
         end else begin
            if (valid_in && ready_out) begin
               d = q2r(x_in) * q2r(x_in) + q2r(y_in) * q2r(y_in) + q2r(z_in) * q2r(z_in);
               pend_sat = (d > 2147483647.0 / 65536.0);
               if (pend_sat) d = 2147483647.0 / 65536.0;
               if (x_in == '0 && y_in == '0 && z_in == '0) begin
                  e = '0;
                  e.due  = cyc + 1 + 4;
                  e.zero = 1'b1;
                  exp_q.push_back(e);
               end else begin
                  pend_x = x_in; pend_y = y_in; pend_z = z_in;
                  pend_dot = d;
                  pend_v   = 1;
               end
            end
            if (isq_valid_out && isq_ready_in) begin
               chk("isq_a_model", pend_v && near(isq_a_out, to_q(pend_dot)),
                   isq_a_out, to_q(pend_dot));
               last_isq_a = isq_a_out;
               rsp_val    = inv_sqrt(isq_a_out);
               rsp_cnt    = 5;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
      @(negedge clk_in);
      x_in = x; y_in = y; z_in = z;
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int req_cycles);
      int n;
      n = 0;
      req_cycles = 0;
      while (n < limit) begin
         @(negedge clk_in);
         #2;
         if (isq_valid_out) req_cycles++;
         if (valid_out) break;
         n++;
      end
      chk("done_timeout", valid_out == 1'b1, valid_out, 1);
      @(negedge clk_in);
      #2;
      chk("valid_pulse_width", valid_out == 1'b0, valid_out, 0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int nreq, n, cnt;
      rst_in = 1'b1;
      valid_in = 1'b0;
      x_in = '0; y_in = '0; z_in = '0;
      isq_ready_in = 1'b1;
      repeat (3) @(negedge clk_in);
      #2;
      chk("rst_ready", ready_out == 1'b1, ready_out, 1);
      chk("rst_valid", valid_out == 1'b0, valid_out, 0);
      chk("rst_isq_valid", isq_valid_out == 1'b0, isq_valid_out, 0);
      chk("rst_isq_a", isq_a_out == '0, isq_a_out, 0);
      chk("rst_x", x_out == '0, x_out, 0);
      chk("rst_flags", {zero_out, sat_out} == 2'b00, {zero_out, sat_out}, 0);
      @(negedge clk_in);
      rst_in = 1'b0;

      // (0.6, 0.8, 0): unit length already
      send(Q_0P6, Q_0P8, Q_ZERO);
      wait_done(40, nreq);
      chk("t1_isq_a", last_isq_a == 32'h00010000, last_isq_a, 32'h00010000);
      chk("t1_x", x_out == 32'h0000999A, x_out, 32'h0000999A);
      chk("t1_y", y_out == 32'h0000CCCD, y_out, 32'h0000CCCD);
      chk("t1_z", z_out == 32'h00000000, z_out, 0);

      // (1, 1, 1)
      send(Q_ONE, Q_ONE, Q_ONE);
      wait_done(40, nreq);
      chk("t2_isq_a", last_isq_a == 32'h00030000, last_isq_a, 32'h00030000);
      chk("t2_x", near(x_out, 32'h000093CD), x_out, 32'h000093CD);
      chk("t2_z", near(z_out, 32'h000093CD), z_out, 32'h000093CD);
      chk("t2_flags", {zero_out, sat_out} == 2'b00, {zero_out, sat_out}, 0);

      // zero vector: no request at all
      send(Q_ZERO, Q_ZERO, Q_ZERO);
      wait_done(40, nreq);
      chk("t3_no_req", nreq == 0, nreq, 0);
      chk("t3_zero", zero_out == 1'b1, zero_out, 1);
      chk("t3_x", x_out == '0, x_out, 0);

      // (-0.6, 0, 0.8) with responder stalled for 20 cycles
      isq_ready_in = 1'b0;
      send(Q_M0P6, Q_ZERO, Q_0P8);
      n = 0;
      #2;
      while (!isq_valid_out && n < 20) begin
         @(negedge clk_in);
         #2;
         n++;
      end
      chk("t4_req_up", isq_valid_out == 1'b1, isq_valid_out, 1);
      repeat (20) begin
         @(negedge clk_in);
         #2;
         chk("t4_hold_valid", isq_valid_out == 1'b1, isq_valid_out, 1);
         chk("t4_hold_a", isq_a_out == 32'h00010000, isq_a_out, 32'h00010000);
         chk("t4_no_out", valid_out == 1'b0, valid_out, 0);
      end
      @(negedge clk_in);
      isq_ready_in = 1'b1;
      wait_done(40, nreq);
      chk("t4_x", x_out == 32'hFFFF6666, x_out, 32'hFFFF6666);
      chk("t4_y", y_out == '0, y_out, 0);
      chk("t4_z", z_out == 32'h0000CCCD, z_out, 32'h0000CCCD);

      // (200, 200, 200): squared length saturates
      send(Q_200, Q_200, Q_200);
      wait_done(40, nreq);
      chk("t5_isq_a", last_isq_a == 32'h7FFFFFFF, last_isq_a, 32'h7FFFFFFF);
      chk("t5_sat", sat_out == 1'b1, sat_out, 1);
      chk("t5_x", near(x_out, 32'h00011AD0), x_out, 32'h00011AD0);

      // reset while waiting for the result, late result must be ignored
      send(Q_0P6, Q_0P8, Q_ZERO);
      n = 0;
      #2;
      while (!isq_valid_out && n < 20) begin
         @(negedge clk_in);
         #2;
         n++;
      end
      chk("t6_req_up", isq_valid_out == 1'b1, isq_valid_out, 1);
      while (isq_valid_out && n < 40) begin
         @(negedge clk_in);
         #2;
         n++;
      end
      chk("t6_req_taken", isq_valid_out == 1'b0, isq_valid_out, 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      #2;
      chk("t6_ready", ready_out == 1'b1, ready_out, 1);
      chk("t6_isq_valid", isq_valid_out == 1'b0, isq_valid_out, 0);
      chk("t6_x_reset", x_out == '0, x_out, 0);
      cnt = 0;
      repeat (10) begin
         @(negedge clk_in);
         #2;
         if (valid_out) cnt++;
      end
      chk("t6_no_valid", cnt == 0, cnt, 0);
      send(Q_0P6, Q_0P8, Q_ZERO);
      wait_done(40, nreq);
      chk("t6_x", x_out == 32'h0000999A, x_out, 32'h0000999A);
      chk("t6_y", y_out == 32'h0000CCCD, y_out, 32'h0000CCCD);

      repeat (3) @(negedge clk_in);
      chk("exp_q_drained", exp_q.size() == 0, exp_q.size(), 0);
      chk("out_count", out_cnt == 6, out_cnt, 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
